// File: rtl/tetris_soc_key_ctrl.sv
// Two-key pushbutton controller: synchronizer, debounce, press/auto-repeat FSM,
// W1C event capture and level irq behind an Avalon-MM slave.
// Build option: define KEY_CTRL_AUTOREPEAT_EN to compile in the DELAY/REPEAT auto-repeat states.
module tetris_soc_key_ctrl #(
  parameter int DEBOUNCE      = 500000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int CNT_W         = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [1:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

`ifdef KEY_CTRL_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} key_st_e;
`else
  typedef enum logic {ST_IDLE, ST_HELD} key_st_e;
`endif

  // Synchronizer flops carry the raw pin level (1 = released).
  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]       sample;
  logic [1:0]       key_state_q, key_state_d;
  logic [CNT_W-1:0] deb_cnt_q [2];
  logic [CNT_W-1:0] deb_cnt_d [2];
  key_st_e          st_q [2];
  key_st_e          st_d [2];
`ifdef KEY_CTRL_AUTOREPEAT_EN
  logic [CNT_W-1:0] rpt_cnt_q [2];
  logic [CNT_W-1:0] rpt_cnt_d [2];
`endif
  logic [1:0]       key_event;
  logic [1:0]       irqmask_q, irqmask_d;
  logic [1:0]       edgecap_q, edgecap_d;
  logic [1:0]       clr_mask;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;

  assign sample = ~sync2_q;
  assign wr_en  = chipselect & write;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    sync1_d     = in_port;
    sync2_d     = sync1_q;
    key_state_d = key_state_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sample[i] != key_state_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) key_state_d[i] = sample[i];
        else                          deb_cnt_d[i]   = deb_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Per-key FSM; a fall of key_state from any state returns to IDLE silently.
  always_comb begin
    key_event = '0;
    for (int i = 0; i < 2; i++) begin
      st_d[i] = st_q[i];
`ifdef KEY_CTRL_AUTOREPEAT_EN
      rpt_cnt_d[i] = '0;
`endif
      if (!key_state_q[i]) begin
        st_d[i] = ST_IDLE;
      end else begin
        case (st_q[i])
`ifdef KEY_CTRL_AUTOREPEAT_EN
          ST_IDLE: begin
            key_event[i] = 1'b1;
            st_d[i]      = ST_DELAY;
          end
          ST_DELAY: begin
            if (rpt_cnt_q[i] == DLY_LAST) begin
              key_event[i] = 1'b1;
              st_d[i]      = ST_REPEAT;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q[i] == PER_LAST) key_event[i] = 1'b1;
            else                          rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_W'(1);
          end
`else
          ST_IDLE: begin
            key_event[i] = 1'b1;
            st_d[i]      = ST_HELD;
          end
          ST_HELD: st_d[i] = ST_HELD;
`endif
          default: st_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Register file; an event beats a same-cycle write-1-to-clear.
  always_comb begin
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr_en && address == 2'd2) irqmask_d = writedata[1:0];
    if (wr_en && address == 2'd3) clr_mask  = writedata[1:0];
    edgecap_d = (edgecap_q & ~clr_mask) | key_event;
    case (address)
      2'd0:    readdata_d = {30'b0, key_state_q};
      2'd2:    readdata_d = {30'b0, irqmask_q};
      2'd3:    readdata_d = {30'b0, edgecap_q};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      key_state_q <= '0;
      irqmask_q   <= '0;
      edgecap_q   <= '0;
      readdata_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
        st_q[i]      <= ST_IDLE;
`ifdef KEY_CTRL_AUTOREPEAT_EN
        rpt_cnt_q[i] <= '0;
`endif
      end
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_state_q <= key_state_d;
      irqmask_q   <= irqmask_d;
      edgecap_q   <= edgecap_d;
      readdata_q  <= readdata_d;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        st_q[i]      <= st_d[i];
`ifdef KEY_CTRL_AUTOREPEAT_EN
        rpt_cnt_q[i] <= rpt_cnt_d[i];
`endif
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

`ifdef KEY_CTRL_AUTOREPEAT_EN
  logic unused_bits;
  assign unused_bits = ^writedata[31:2];
`else
  logic unused_bits;
  assign unused_bits = ^{writedata[31:2], 1'(REPEAT_DELAY), 1'(REPEAT_PERIOD)};
`endif

endmodule

// File: tb/tb_tetris_soc_key_ctrl.sv
// Self-checking bench for tetris_soc_key_ctrl: directed steps plus a random phase,
// every cycle compared against a window/arithmetic reference model.
module tb_tetris_soc_key_ctrl;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int HD = D + 2;
`ifdef KEY_CTRL_AUTOREPEAT_EN
  localparam int NEXP = 4;
`else
  localparam int NEXP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [1:0] mon_addr;

  // Reference model state
  logic [1:0]  m_ks, m_mask, m_ec;
  logic [31:0] m_rd;
  logic        m_irq;
  logic [1:0]  m_hist [HD];
  int          m_press [2];

  tetris_soc_key_ctrl #(
    .DEBOUNCE(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ks = '0; m_mask = '0; m_ec = '0; m_rd = '0; m_irq = 1'b0;
    for (int j = 0; j < HD; j++) m_hist[j] = 2'b11;
    m_press[0] = 0; m_press[1] = 0;
  endtask

  // One clock edge: key accepted after D consecutive differing synced samples;
  // events at press+1, then (AR) press+1+RD+k*RP while held.
  task automatic model_edge();
    logic [1:0] ev, clr;
    logic       all_diff;
    int         h;
    case (address)
      2'd0:    m_rd = {30'b0, m_ks};
      2'd2:    m_rd = {30'b0, m_mask};
      2'd3:    m_rd = {30'b0, m_ec};
      default: m_rd = '0;
    endcase
    ev = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_ks[i]) begin
        h = cyc - m_press[i] - 1;
        if (h == 0) ev[i] = 1'b1;
`ifdef KEY_CTRL_AUTOREPEAT_EN
        else if (h >= RD && (h - RD) % RP == 0) ev[i] = 1'b1;
`endif
      end
    end
    clr = (chipselect && write && address == 2'd3) ? writedata[1:0] : 2'b00;
    if (chipselect && write && address == 2'd2) m_mask = writedata[1:0];
    m_ec = (m_ec & ~clr) | ev;
    for (int j = HD - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = in_port;
    for (int i = 0; i < 2; i++) begin
      all_diff = 1'b1;
      for (int j = 2; j < D + 2; j++) if (!m_hist[j][i] == m_ks[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_ks[i] = ~m_ks[i];
        if (m_ks[i]) m_press[i] = cyc;
      end
    end
    m_irq = |(m_ec & m_mask);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset) model_reset();
    else       model_edge();
    #1;
    check("readdata", readdata, m_rd);
    check("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic set_addr(input logic [1:0] a);
    mon_addr = a;
    address  = a;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write = 1'b1; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0; writedata = $urandom(); address = mon_addr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int P, guard, extra;
    int evq[$];
    reset = 1'b1; address = '0; chipselect = 1'b0; write = 1'b0;
    writedata = '0; in_port = 2'b11; mon_addr = '0;
    model_reset();

    // Reset and idle
    repeat (3) tick();
    check("rst_rd", readdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int n = 0; n < 50; n++) begin
      set_addr(2'(n % 4));
      tick();
      check("idle_rd", readdata, 32'd0);
    end

    // Bounce shorter than DEBOUNCE is rejected
    set_addr(2'd0);
    in_port = 2'b10; repeat (3) tick();
    in_port = 2'b11; repeat (10) tick();
    check("bounce_ks", readdata, 32'd0);
    set_addr(2'd3); tick();
    check("bounce_ec", readdata, 32'd0);

    // Press key 0: key_state 6 cycles after pin, capture and irq one cycle later
    bus_write(2'd2, 32'd1);
    set_addr(2'd0);
    in_port = 2'b10; P = cyc;
    repeat (6) tick();
    check("ks_lag", readdata, 32'd0);
    check("irq_lag", {31'b0, irq}, 32'd0);
    tick();
    check("ks_on", readdata, 32'd1);
    check("irq_on", {31'b0, irq}, 32'd1);
    set_addr(2'd3); tick();
    check("ec_on", readdata, 32'd1);
    bus_write(2'd3, 32'd1);
    check("irq_clr", {31'b0, irq}, 32'd0);
    tick();
    check("ec_clr", readdata, 32'd0);
    in_port = 2'b11;
    repeat (15) tick();
    check("rel_ec", readdata, 32'd0);
    check("rel_irq", {31'b0, irq}, 32'd0);

    // Hold key 1, clear after each event, check event spacing
    bus_write(2'd2, 32'd3);
    set_addr(2'd3);
    in_port = 2'b01; P = cyc; guard = 0;
    while (evq.size() < NEXP && guard < 60) begin
      tick(); guard++;
      if (irq) begin
        evq.push_back(cyc);
        bus_write(2'd3, 32'd2);
      end
    end
    check("ev_count", 32'(evq.size()), 32'(NEXP));
    if (evq.size() == NEXP) begin
      check("ev_t0", 32'(evq[0] - P), 32'd7);
`ifdef KEY_CTRL_AUTOREPEAT_EN
      check("ev_t1", 32'(evq[1] - evq[0]), 32'd10);
      check("ev_t2", 32'(evq[2] - evq[0]), 32'd13);
      check("ev_t3", 32'(evq[3] - evq[0]), 32'd16);
`endif
    end
`ifndef KEY_CTRL_AUTOREPEAT_EN
    extra = 0;
    repeat (30) begin tick(); if (irq) extra++; end
    check("no_repeat", 32'(extra), 32'd0);
`endif
    in_port = 2'b11;
    repeat (10) tick();
    bus_write(2'd3, 32'd3);
    extra = 0;
    repeat (20) begin tick(); if (irq) extra++; end
    check("post_release", 32'(extra), 32'd0);

    // Clear in the same cycle as an event: set wins
    in_port = 2'b01; P = cyc;
    while (cyc < P + 6) tick();
    bus_write(2'd3, 32'd2);
    check("setwin_press", {31'b0, irq}, 32'd1);
    tick();
    check("setwin_press_ec", readdata, 32'd2);
`ifdef KEY_CTRL_AUTOREPEAT_EN
    bus_write(2'd3, 32'd2);
    check("setwin_clr", {31'b0, irq}, 32'd0);
    while (cyc < P + 16) tick();
    bus_write(2'd3, 32'd2);
    check("setwin_repeat", {31'b0, irq}, 32'd1);
`endif
    in_port = 2'b11;
    repeat (10) tick();
    bus_write(2'd3, 32'd3);

    // Reset while key 0 is auto-repeating with the pin held low
    in_port = 2'b10;
    repeat (25) tick();
    #2; reset = 1'b1; model_reset();
    #1;
    check("mid_rst_rd", readdata, 32'd0);
    check("mid_rst_irq", {31'b0, irq}, 32'd0);
    repeat (2) tick();
    set_addr(2'd3);
    @(negedge clk); reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("post_rst_quiet", readdata, 32'd0);
    end
    tick();
    check("post_rst_event", readdata, 32'd1);
    in_port = 2'b11;
    repeat (10) tick();

    // Random phase against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      if ($urandom_range(0, 15) == 0) in_port[$urandom_range(0, 1)] ^= 1'b1;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        set_addr(2'($urandom_range(0, 3)));
        bus_write(2'($urandom_range(0, 3)), $urandom());
      end else begin
        address    = 2'($urandom_range(0, 3));
        mon_addr   = address;
        chipselect = (r == 1);
        write      = (r == 2);
        writedata  = $urandom();
        tick();
      end
    end
    chipselect = 1'b0; write = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
